// File: rtl/seq_arith_nx1b_addsub.sv
// Bit-serial LSB-first adder/subtractor with per-word mode latch,
// zero-latency result bits and end-of-word carry/overflow flags.
module seq_arith_nx1b_addsub #(
  parameter int NBITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_val,
  input  logic in0,
  input  logic in1,
  input  logic sub,
  output logic out_val,
  output logic out,
  output logic last,
  output logic cout,
  output logic ovf
);

  localparam int IW = $clog2(NBITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBITS - 1);

  logic [IW-1:0] idx;
  logic          carry_r;
  logic          mode_r;

  logic first;
  logic at_last;
  logic m;
  logic b;
  logic c;
  logic s;
  logic co;

  always_comb begin
    first   = (idx == '0);
    at_last = (idx == LAST_IDX);
    m       = first ? sub : mode_r;
    b       = in1 ^ m;
    // Seeding the carry with the mode supplies the +1 of ~B+1.
    c       = first ? m : carry_r;
    s       = in0 ^ b ^ c;
    co      = (in0 & b) | (in0 & c) | (b & c);
    out_val = in_val & ~reset;
    out     = out_val & s;
    last    = out_val & at_last;
    cout    = last & co;
    ovf     = last & (c ^ co);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      carry_r <= 1'b0;
      mode_r  <= 1'b0;
    end else if (in_val) begin
      carry_r <= co;
      if (first)
        mode_r <= sub;
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

endmodule
